mult_wide_iter: RTL and testbench



---
 rtl/mult_wide_iter_pkg.sv | 25 ++
 rtl/mult_wide_iter_if.sv | 31 +++
 rtl/mult_wide_iter_row_dsp.sv | 48 ++++
 rtl/mult_wide_iter.sv | 152 +++++++++++++++
 tb/tb_mult_wide_iter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_wide_iter_pkg.sv
// ----------------------------------------------------------------------------
// mm_mult_pkg
// Shared definitions for the iterative wide multiplier (mult_wide_iter):
//   - state_e   : controller states
//   - ceil_div  : integer ceiling division used to size chunk/digit counts
//   - DSP_A_MAX / DSP_B_MAX : unsigned operand limits of one DSP multiplier
//     (signed A/B ports with the sign bit removed)
// ----------------------------------------------------------------------------
package mm_mult_pkg;

    localparam int DSP_A_MAX = 26;
    localparam int DSP_B_MAX = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/mult_wide_iter_if.sv
// ----------------------------------------------------------------------------
// mult_wide_iter_if
// Operand/result handshake bundle of the wide multiplier.
//   in_valid/in_ready   : operand handshake, a (WIDTH_A) and b (WIDTH_B)
//   out_valid/out_ready : product handshake, p (WIDTH_A+WIDTH_B)
//   busy                : multiplier is not idle
// master = producer/consumer side, slave = multiplier side.
// ----------------------------------------------------------------------------
interface mult_wide_iter_if #(
    parameter int WIDTH_A = 128,
    parameter int WIDTH_B = 128
);
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH_A-1:0]         a;
    logic [WIDTH_B-1:0]         b;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH_A+WIDTH_B-1:0] p;
    logic                       busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/mult_wide_iter_row_dsp.sv
// ----------------------------------------------------------------------------
// mult_row_dsp
// Combinational WIDTH_A x DIGIT_W unsigned row product. Operand a is split
// into DSP_NUM chunks of WIDTH_DSP bits (top chunk zero-padded); each chunk is
// multiplied by the digit and the partial products are summed at their chunk
// offsets.
//   a   : multiplicand (WIDTH_A)
//   d   : multiplier digit (DIGIT_W)
//   row : a * d (WIDTH_A+DIGIT_W, exact)
// ----------------------------------------------------------------------------
module mult_row_dsp
    import mm_mult_pkg::*;
#(
    parameter int WIDTH_A   = 128,
    parameter int DIGIT_W   = 16,
    parameter int WIDTH_DSP = 26
) (
    input  logic [WIDTH_A-1:0]         a,
    input  logic [DIGIT_W-1:0]         d,
    output logic [WIDTH_A+DIGIT_W-1:0] row
);
    localparam int DSP_NUM = ceil_div(WIDTH_A, WIDTH_DSP);
    localparam int PAD_W   = DSP_NUM * WIDTH_DSP;
    localparam int PROD_W  = WIDTH_DSP + DIGIT_W;
    localparam int ROW_W   = WIDTH_A + DIGIT_W;

    logic [PAD_W-1:0]  a_pad;
    logic [PROD_W-1:0] prod [DSP_NUM];
    logic [ROW_W-1:0]  sum;

    assign a_pad = PAD_W'(a);

    for (genvar j = 0; j < DSP_NUM; j++) begin : g_chunk
        assign prod[j] = PROD_W'(a_pad[j*WIDTH_DSP +: WIDTH_DSP]) * PROD_W'(d);
    end

    // The true row value fits in ROW_W bits, so truncating each shifted
    // chunk product to ROW_W never loses significant bits of the sum.
    always_comb begin
        sum = '0;
        for (int j = 0; j < DSP_NUM; j++) begin
            sum = sum + (ROW_W'(prod[j]) << (j * WIDTH_DSP));
        end
    end

    assign row = sum;

endmodule

// File: rtl/mult_wide_iter.sv
// ----------------------------------------------------------------------------
// mult_wide_iter
// Iterative handshaked unsigned multiplier p = a * b. Operand b is consumed
// one DIGIT_W digit per cycle; each digit row (a * digit) is shift-accumulated
// into a full-width accumulator. Optional register between row and
// accumulator (PIPE) and early termination when the remaining b digits are
// zero (EARLY_EXIT).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mult_wide_iter_if.slave (in_valid/in_ready/a/b,
//                out_valid/out_ready/p, busy)
// ----------------------------------------------------------------------------
module mult_wide_iter
    import mm_mult_pkg::*;
#(
    parameter int WIDTH_A    = 128,
    parameter int WIDTH_B    = 128,
    parameter int DIGIT_W    = 16,
    parameter int WIDTH_DSP  = 26,
    parameter int PIPE       = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_wide_iter_if.slave bus
);
    localparam int NUM_DIG = ceil_div(WIDTH_B, DIGIT_W);
    localparam int CNT_W   = $clog2(NUM_DIG + 1);
    localparam int BPAD_W  = NUM_DIG * DIGIT_W;
    localparam int P_W     = WIDTH_A + WIDTH_B;
    localparam int ROW_W   = WIDTH_A + DIGIT_W;

    if (DIGIT_W > DSP_B_MAX) begin : g_bad_digit_w
        $error("DIGIT_W exceeds the unsigned DSP B port width");
    end
    if (WIDTH_DSP > DSP_A_MAX) begin : g_bad_width_dsp
        $error("WIDTH_DSP exceeds the unsigned DSP A port width");
    end

    state_e             state_q,  state_d;
    logic [WIDTH_A-1:0] a_q,      a_d;
    logic [BPAD_W-1:0]  b_q,      b_d;      // remaining digits, current digit at LSB
    logic [CNT_W-1:0]   k_q,      k_d;
    logic [P_W-1:0]     acc_q,    acc_d;
    logic [ROW_W-1:0]   row_p1_q, row_p1_d;
    logic [CNT_W-1:0]   k_p1_q,   k_p1_d;
    logic               vld_p1_q, vld_p1_d;

    logic [ROW_W-1:0]   row_now;
    logic [ROW_W-1:0]   add_row;
    logic [CNT_W-1:0]   add_k;
    logic               add_en;
    logic               upper_zero;
    logic               last;

    mult_row_dsp #(
        .WIDTH_A   (WIDTH_A),
        .DIGIT_W   (DIGIT_W),
        .WIDTH_DSP (WIDTH_DSP)
    ) u_row (
        .a   (a_q),
        .d   (b_q[DIGIT_W-1:0]),
        .row (row_now)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            row_p1_q <= '0;
            k_p1_q   <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            row_p1_q <= row_p1_d;
            k_p1_q   <= k_p1_d;
            vld_p1_q <= vld_p1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        acc_d    = acc_q;
        row_p1_d = row_p1_q;
        k_p1_d   = k_p1_q;
        vld_p1_d = 1'b0;

        // b_q is shifted down as digits are consumed, so everything above the
        // LSB digit is exactly "b bits above digit k".
        upper_zero = ((b_q >> DIGIT_W) == '0);
        last       = (k_q == CNT_W'(NUM_DIG - 1)) || ((EARLY_EXIT != 0) && upper_zero);

        // With PIPE the accumulate uses the row/k registered one cycle earlier.
        add_row = (PIPE != 0) ? row_p1_q : row_now;
        add_k   = (PIPE != 0) ? k_p1_q   : k_q;
        add_en  = (PIPE != 0) ? vld_p1_q : (state_q == BUSY);

        if (add_en) begin
            acc_d = acc_q + (P_W'(add_row) << (32'(add_k) * DIGIT_W));
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = BPAD_W'(bus.b);
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                row_p1_d = row_now;
                k_p1_d   = k_q;
                vld_p1_d = 1'b1;
                b_d      = b_q >> DIGIT_W;
                if (last) begin
                    state_d = (PIPE != 0) ? DRAIN : DONE;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        // The accumulator only reaches the port once it holds the full result.
        bus.p         = (state_q == DONE) ? acc_q : '0;
    end

endmodule

// File: tb/tb_mult_wide_iter.sv
// ----------------------------------------------------------------------------
// tb_mult_wide_iter
// Bench for mult_wide_iter. Four instances cover the configurations:
//   u0: 128x128 PIPE=0 EARLY_EXIT=1 (defaults)
//   u1: 128x128 PIPE=0 EARLY_EXIT=0
//   u2: 130x100 PIPE=1 EARLY_EXIT=1
//   u3:  64x16  PIPE=1 EARLY_EXIT=0
// Expected products come from plain a*b, expected latency from digit counts.
// ----------------------------------------------------------------------------
module tb_mult_wide_iter;
    import mm_mult_pkg::*;

    localparam int NU = 4;
    localparam int PW = 258;
    localparam int DW = 16;

    localparam int CFG_WA   [NU] = '{128, 128, 130, 64};
    localparam int CFG_WB   [NU] = '{128, 128, 100, 16};
    localparam int CFG_PIPE [NU] = '{0, 0, 1, 1};
    localparam int CFG_EE   [NU] = '{1, 0, 1, 0};

    logic clk;
    logic rst_n;

    logic          in_valid_t  [NU];
    logic          out_ready_t [NU];
    logic [129:0]  a_t         [NU];
    logic [127:0]  b_t         [NU];
    logic          in_ready_o  [NU];
    logic          out_valid_o [NU];
    logic          busy_o      [NU];
    logic [PW-1:0] p_o         [NU];

    int n_checks;
    int n_fail;

    mult_wide_iter_if #(.WIDTH_A(128), .WIDTH_B(128)) bus0 ();
    mult_wide_iter_if #(.WIDTH_A(128), .WIDTH_B(128)) bus1 ();
    mult_wide_iter_if #(.WIDTH_A(130), .WIDTH_B(100)) bus2 ();
    mult_wide_iter_if #(.WIDTH_A(64),  .WIDTH_B(16))  bus3 ();

    assign bus0.in_valid = in_valid_t[0];  assign bus0.out_ready = out_ready_t[0];
    assign bus0.a = 128'(a_t[0]);          assign bus0.b = 128'(b_t[0]);
    assign in_ready_o[0] = bus0.in_ready;  assign out_valid_o[0] = bus0.out_valid;
    assign busy_o[0] = bus0.busy;          assign p_o[0] = PW'(bus0.p);

    assign bus1.in_valid = in_valid_t[1];  assign bus1.out_ready = out_ready_t[1];
    assign bus1.a = 128'(a_t[1]);          assign bus1.b = 128'(b_t[1]);
    assign in_ready_o[1] = bus1.in_ready;  assign out_valid_o[1] = bus1.out_valid;
    assign busy_o[1] = bus1.busy;          assign p_o[1] = PW'(bus1.p);

    assign bus2.in_valid = in_valid_t[2];  assign bus2.out_ready = out_ready_t[2];
    assign bus2.a = 130'(a_t[2]);          assign bus2.b = 100'(b_t[2]);
    assign in_ready_o[2] = bus2.in_ready;  assign out_valid_o[2] = bus2.out_valid;
    assign busy_o[2] = bus2.busy;          assign p_o[2] = PW'(bus2.p);

    assign bus3.in_valid = in_valid_t[3];  assign bus3.out_ready = out_ready_t[3];
    assign bus3.a = 64'(a_t[3]);           assign bus3.b = 16'(b_t[3]);
    assign in_ready_o[3] = bus3.in_ready;  assign out_valid_o[3] = bus3.out_valid;
    assign busy_o[3] = bus3.busy;          assign p_o[3] = PW'(bus3.p);

    mult_wide_iter #(.WIDTH_A(128), .WIDTH_B(128), .DIGIT_W(16), .WIDTH_DSP(26),
                     .PIPE(0), .EARLY_EXIT(1))
        u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mult_wide_iter #(.WIDTH_A(128), .WIDTH_B(128), .DIGIT_W(16), .WIDTH_DSP(26),
                     .PIPE(0), .EARLY_EXIT(0))
        u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mult_wide_iter #(.WIDTH_A(130), .WIDTH_B(100), .DIGIT_W(16), .WIDTH_DSP(26),
                     .PIPE(1), .EARLY_EXIT(1))
        u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    mult_wide_iter #(.WIDTH_A(64), .WIDTH_B(16), .DIGIT_W(16), .WIDTH_DSP(26),
                     .PIPE(1), .EARLY_EXIT(0))
        u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [259:0] rand260();
        logic [287:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return 260'(r);
    endfunction

    function automatic logic [259:0] mask_w(input int w);
        return (260'(1) << w) - 260'(1);
    endfunction

    // Cycles from accept to first out_valid: number of digits processed
    // (all digits, or only up to the highest non-zero one) plus the pipe stage.
    function automatic int exp_lat(input int u, input logic [259:0] bv);
        int blen;
        int neff;
        blen = 0;
        for (int i = 0; i < 260; i++) begin
            if (bv[i]) blen = i + 1;
        end
        if (CFG_EE[u] != 0) begin
            neff = (blen + DW - 1) / DW;
            if (neff < 1) neff = 1;
        end else begin
            neff = (CFG_WB[u] + DW - 1) / DW;
        end
        return neff + CFG_PIPE[u];
    endfunction

    // Offers one operand pair, returns once out_valid is seen (or the bound
    // expires) with the product and the accept-to-valid cycle count.
    task automatic run_txn(input int u, input logic [259:0] av, input logic [259:0] bv,
                           output logic [PW-1:0] pv, output int lat, output int drains);
        int guard;
        guard  = 0;
        drains = 0;
        while (!in_ready_o[u] && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check_eq("in_ready_timeout", 0, 1);
        a_t[u]        = 130'(av);
        b_t[u]        = 128'(bv);
        in_valid_t[u] = 1'b1;
        @(posedge clk); #1;
        in_valid_t[u] = 1'b0;
        check_eq("accept_in_ready_low", PW'(in_ready_o[u]), 0);
        check_eq("accept_busy_high", PW'(busy_o[u]), 1);
        lat = 0;
        while (!out_valid_o[u] && lat < 64) begin
            if (u == 2 && u2.state_q == DRAIN) drains++;
            @(posedge clk); #1;
            lat++;
        end
        pv = p_o[u];
    endtask

    task automatic handoff(input int u);
        out_ready_t[u] = 1'b1;
        @(posedge clk); #1;
        check_eq("handoff_out_valid_drop", PW'(out_valid_o[u]), 0);
        check_eq("handoff_in_ready_rise", PW'(in_ready_o[u]), 1);
    endtask

    initial begin
        logic [259:0]  av;
        logic [259:0]  bv;
        logic [PW-1:0] pv;
        logic [PW-1:0] exp;
        int lat;
        int drains;
        int bl;
        int stall;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int u = 0; u < NU; u++) begin
            in_valid_t[u]  = 1'b0;
            out_ready_t[u] = 1'b1;
            a_t[u]         = '0;
            b_t[u]         = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int u = 0; u < NU; u++) begin
            check_eq("reset_in_ready", PW'(in_ready_o[u]), 1);
            check_eq("reset_out_valid", PW'(out_valid_o[u]), 0);
            check_eq("reset_busy", PW'(busy_o[u]), 0);
            check_eq("reset_p", p_o[u], 0);
        end

        // Full-width all-ones operands.
        av = mask_w(128);
        run_txn(0, av, av, pv, lat, drains);
        exp = (PW'(1) << 256) - (PW'(1) << 129) + PW'(1);
        check_eq("max_product", pv, exp);
        check_eq("max_latency", PW'(lat), 8);
        handoff(0);

        // Single-digit b: early exit versus full iteration.
        av = 260'(1) << 64;
        run_txn(0, av, 260'(5), pv, lat, drains);
        check_eq("ee_product", pv, PW'(5) << 64);
        check_eq("ee_latency", PW'(lat), 1);
        handoff(0);
        run_txn(1, av, 260'(5), pv, lat, drains);
        check_eq("noee_product", pv, PW'(5) << 64);
        check_eq("noee_latency", PW'(lat), 8);
        handoff(1);

        // b = 0, with and without the pipe stage.
        av = rand260() & mask_w(128);
        run_txn(0, av, 260'(0), pv, lat, drains);
        check_eq("bzero_product", pv, 0);
        check_eq("bzero_latency", PW'(lat), 1);
        handoff(0);
        av = rand260() & mask_w(130);
        run_txn(2, av, 260'(0), pv, lat, drains);
        check_eq("bzero_pipe_product", pv, 0);
        check_eq("bzero_pipe_latency", PW'(lat), 2);
        check_eq("bzero_pipe_drain_once", PW'(drains), 1);
        handoff(2);

        // Backpressure: result held, new operands ignored, then clean handoff.
        out_ready_t[0] = 1'b0;
        av  = rand260() & mask_w(128);
        bv  = rand260() & mask_w(128);
        exp = PW'(av) * PW'(bv);
        run_txn(0, av, bv, pv, lat, drains);
        check_eq("bp_product", pv, exp);
        for (int c = 0; c < 20; c++) begin
            in_valid_t[0] = c[0];
            a_t[0] = 130'(rand260());
            b_t[0] = 128'(rand260());
            @(posedge clk); #1;
            check_eq("bp_p_stable", p_o[0], exp);
            check_eq("bp_out_valid_held", PW'(out_valid_o[0]), 1);
            check_eq("bp_in_ready_low", PW'(in_ready_o[0]), 0);
        end
        in_valid_t[0] = 1'b0;
        handoff(0);
        av = rand260() & mask_w(128);
        bv = rand260() & mask_w(128);
        run_txn(0, av, bv, pv, lat, drains);
        check_eq("bp_next_product", pv, PW'(av) * PW'(bv));
        handoff(0);

        // Reset pulse in the third BUSY cycle of a full-width operation.
        a_t[0]        = 130'(mask_w(128));
        b_t[0]        = 128'(mask_w(128));
        in_valid_t[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_t[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", PW'(out_valid_o[0]), 0);
        check_eq("rst_p", p_o[0], 0);
        check_eq("rst_in_ready", PW'(in_ready_o[0]), 1);
        check_eq("rst_busy", PW'(busy_o[0]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            check_eq("rst_no_stale_valid", PW'(out_valid_o[0]), 0);
        end
        run_txn(0, 260'(3), 260'(7), pv, lat, drains);
        check_eq("rst_after_product", pv, 21);
        check_eq("rst_after_latency", PW'(lat), 1);
        handoff(0);

        // Randomised regression over all configurations.
        for (int u = 0; u < NU; u++) begin
            for (int n = 0; n < 150; n++) begin
                av = rand260() & mask_w(CFG_WA[u]);
                if ($urandom_range(0, 7) == 0) av = mask_w(CFG_WA[u]);
                case ($urandom_range(0, 3))
                    0:       bl = CFG_WB[u];
                    1:       bl = $urandom_range(0, DW);
                    default: bl = $urandom_range(0, CFG_WB[u]);
                endcase
                bv = rand260() & mask_w(bl);
                if ($urandom_range(0, 7) == 0) bv = mask_w(CFG_WB[u]);
                exp   = PW'(av) * PW'(bv);
                stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                out_ready_t[u] = (stall == 0);
                run_txn(u, av, bv, pv, lat, drains);
                check_eq("rnd_product", pv, exp);
                check_eq("rnd_latency", PW'(lat), PW'(exp_lat(u, bv)));
                if (stall > 0) begin
                    repeat (stall) @(posedge clk);
                    #1;
                    check_eq("rnd_stall_p", p_o[u], exp);
                end
                handoff(u);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
